// File: rtl/debug_view_pkg.sv
// Shared types and helpers for the debug display controller.
//   seg7_t      : one 7-segment digit, active-low, segment a in the MSB
//   SEG_BLANK   : all segments dark
//   SEG_ZERO    : glyph "0"
//   width_of()  : ceil(log2(n)), never less than 1 (counter / select widths)
//   hex_to_seg(): nibble to DE2-style active-low glyph (0-9, A, b, C, d, E, F)
package debug_view_pkg;

    typedef logic [0:6] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;
    localparam seg7_t SEG_ZERO  = 7'b0000001;

    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic seg7_t hex_to_seg(input logic [3:0] nib);
        seg7_t seg;
        case (nib)
            4'h0:    seg = SEG_ZERO;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/debug_view_ctrl_key_conditioner.sv
// Conditions one raw, bouncy, active-low push button.
//   CLK, Reset_n : clock, asynchronous active-low reset
//   raw_n        : raw KEY input, asynchronous to CLK
//   stable_n     : debounced level (changes after DEBOUNCE_CYC equal samples)
//   press_pulse  : one-cycle pulse on each accepted 1->0 transition
module key_conditioner
    import debug_view_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic raw_n,
    output logic stable_n,
    output logic press_pulse
);

    localparam int               CNT_W    = width_of(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        sync1_d  = raw_n;
        sync2_d  = sync1_q;
        cnt_d    = '0;
        stable_d = stable_q;
        // cnt_q counts consecutive samples that disagree with the stable level.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = stable_q & ~stable_d;
    end

    // Everything resets to the "held" level: a button already down at reset
    // release never produces a 1->0 edge until it has been released first.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign stable_n    = stable_q;
    assign press_pulse = press_q;

endmodule

// File: rtl/debug_view_ctrl.sv
// Debug display controller: selects one of NUM_CH probe words (manual switch
// or auto-scan), optionally freezes a snapshot of all channels on a debounced
// button press, and drives active-low 7-segment digits, one per nibble.
//   CLK, Reset_n : clock, asynchronous active-low reset
//   ch_data      : NUM_CH probe words, channel k at [k*CH_W +: CH_W]
//   sel_sw       : raw manual channel select
//   mode_auto    : raw switch, 1 = auto-scan, 0 = manual
//   freeze_btn_n : raw active-low freeze button
//   hex_seg      : digit d at [7*d +: 7], segment a in the MSB, active-low
//   cur_ch       : channel being displayed
//   frozen       : snapshot mode active
//   sel_err      : manual select out of range (display forced to zero)
module debug_view_ctrl
    import debug_view_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int CH_W         = 16,
    parameter int SCAN_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int SEL_W        = width_of(NUM_CH)
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    input  logic [NUM_CH*CH_W-1:0]   ch_data,
    input  logic [SEL_W-1:0]         sel_sw,
    input  logic                     mode_auto,
    input  logic                     freeze_btn_n,
    output logic [7*(CH_W/4)-1:0]    hex_seg,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     frozen,
    output logic                     sel_err
);

    localparam int                 DIGITS     = CH_W / 4;
    localparam int                 PRESC_W    = width_of(SCAN_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]   CH_LAST    = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic               mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               frozen_q, frozen_d;
    logic [CH_W-1:0]    snap_q [NUM_CH];
    logic [CH_W-1:0]    snap_d [NUM_CH];
    logic [CH_W-1:0]    disp_q, disp_d;

    logic [CH_W-1:0]    live [NUM_CH];
    logic [CH_W-1:0]    word;
    logic               sel_legal;
    logic               press_pulse;
    logic               btn_stable_n_unused;

    key_conditioner #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_freeze_key (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .raw_n       (freeze_btn_n),
        .stable_n    (btn_stable_n_unused),
        .press_pulse (press_pulse)
    );

    always_comb begin
        sel_s1_d  = sel_sw;
        sel_s2_d  = sel_s1_q;
        mode_s1_d = mode_auto;
        mode_s2_d = mode_s1_q;

        sel_legal = (32'(sel_s2_q) < NUM_CH);

        // Channel index. ch_q only ever holds legal values; in manual mode the
        // synced switch is shown directly so a switch change reaches the
        // display register one cycle after the synchroniser.
        presc_d = '0;
        ch_d    = ch_q;
        if (mode_s2_q) begin
            if (presc_q == PRESC_LAST) begin
                ch_d = (ch_q == CH_LAST) ? '0 : ch_q + SEL_W'(1);
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end else if (sel_legal) begin
            ch_d = sel_s2_q;
        end
        cur_ch  = (!mode_s2_q && sel_legal) ? sel_s2_q : ch_q;
        sel_err = !mode_s2_q && !sel_legal;

        // Freeze toggle; the snapshot is taken only on the way into frozen.
        frozen_d = frozen_q ^ press_pulse;
        snap_d   = snap_q;
        for (int k = 0; k < NUM_CH; k++) begin
            live[k] = ch_data[k*CH_W +: CH_W];
            if (press_pulse && !frozen_q) begin
                snap_d[k] = live[k];
            end
        end

        word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch == SEL_W'(k)) begin
                word = frozen_q ? snap_q[k] : live[k];
            end
        end
        disp_d = sel_err ? '0 : word;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_s1_q  <= '0;
            sel_s2_q  <= '0;
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            presc_q   <= '0;
            ch_q      <= '0;
            frozen_q  <= 1'b0;
            // NOTE: the snapshot bank is small and must read zero after reset, so it is reset explicitly.
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= '0;
            end
            disp_q    <= '0;
        end else begin
            sel_s1_q  <= sel_s1_d;
            sel_s2_q  <= sel_s2_d;
            mode_s1_q <= mode_s1_d;
            mode_s2_q <= mode_s2_d;
            presc_q   <= presc_d;
            ch_q      <= ch_d;
            frozen_q  <= frozen_d;
            snap_q    <= snap_d;
            disp_q    <= disp_d;
        end
    end

    always_comb begin
        hex_seg = '0;
        for (int d = 0; d < DIGITS; d++) begin
            hex_seg[7*d +: 7] = hex_to_seg(disp_q[4*d +: 4]);
        end
    end

    assign frozen = frozen_q;

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Self-checking bench for debug_view_ctrl (NUM_CH=4, CH_W=16, SCAN_DIV=8,
// DEBOUNCE_CYC=4, SEL_W=3 so out-of-range selects are reachable).
module tb_debug_view_ctrl;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 16;
    localparam int SDIV   = 8;
    localparam int DEB    = 4;
    localparam int SEL_W  = 3;

    logic                   CLK;
    logic                   Reset_n;
    logic [NUM_CH*CH_W-1:0] ch_data;
    logic [SEL_W-1:0]       sel_sw;
    logic                   mode_auto;
    logic                   freeze_btn_n;
    logic [27:0]            hex_seg;
    logic [SEL_W-1:0]       cur_ch;
    logic                   frozen;
    logic                   sel_err;

    int tests_run    = 0;
    int tests_failed = 0;

    debug_view_ctrl #(
        .NUM_CH       (NUM_CH),
        .CH_W         (CH_W),
        .SCAN_DIV     (SDIV),
        .DEBOUNCE_CYC (DEB),
        .SEL_W        (SEL_W)
    ) dut (
        .CLK          (CLK),
        .Reset_n      (Reset_n),
        .ch_data      (ch_data),
        .sel_sw       (sel_sw),
        .mode_auto    (mode_auto),
        .freeze_btn_n (freeze_btn_n),
        .hex_seg      (hex_seg),
        .cur_ch       (cur_ch),
        .frozen       (frozen),
        .sel_err      (sel_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- glyphs: which segments light for each hex digit ----
    function automatic string glyph_of(input int v);
        case (v)
            0: return "abcdef";   1: return "bc";      2: return "abdeg";
            3: return "abcdg";    4: return "bcfg";    5: return "acdfg";
            6: return "acdefg";   7: return "abc";     8: return "abcdefg";
            9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
           12: return "adef";    13: return "bcdeg";  14: return "adefg";
            default: return "aefg";
        endcase
    endfunction

    function automatic logic [6:0] glyph_seg(input int v);
        string      g;
        logic [6:0] s;
        s = 7'h7F;
        g = glyph_of(v);
        for (int i = 0; i < g.len(); i++) s[6 - (int'(g[i]) - 97)] = 1'b0;
        return s;
    endfunction

    function automatic logic [27:0] exp_hex(input int w);
        logic [27:0] r;
        r = '0;
        for (int d = 0; d < 4; d++) r[7*d +: 7] = glyph_seg((w >> (4*d)) & 15);
        return r;
    endfunction

    // ---------------- behavioural reference model ------------------------
    int m_sel_p, m_sel_s, m_mode_p, m_mode_s, m_btn_p, m_btn_s;
    int m_stable, m_run, m_pend;
    int m_frozen, m_ch, m_presc, m_disp;
    int m_snap [NUM_CH];

    function automatic int live(input int k);
        return int'(ch_data[k*CH_W +: CH_W]);
    endfunction

    function automatic int exp_cur();
        return (m_mode_s == 0 && m_sel_s < NUM_CH) ? m_sel_s : m_ch;
    endfunction

    function automatic int exp_err();
        return (m_mode_s == 0 && m_sel_s >= NUM_CH) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_sel_p = 0;  m_sel_s = 0;  m_mode_p = 0;  m_mode_s = 0;
        m_btn_p = 0;  m_btn_s = 0;  m_stable = 0;  m_run = 0;  m_pend = 0;
        m_frozen = 0; m_ch = 0;     m_presc = 0;   m_disp = 0;
        for (int k = 0; k < NUM_CH; k++) m_snap[k] = 0;
    endtask

    task automatic model_step();
        int cur, word, press, legal;
        legal = (m_sel_s < NUM_CH);
        cur   = exp_cur();
        if (m_mode_s == 0 && !legal) word = 0;
        else                         word = m_frozen ? m_snap[cur] : live(cur);
        press  = m_pend;
        m_pend = 0;
        if (m_btn_s != m_stable) begin
            m_run++;
            if (m_run == DEB) begin
                m_stable = m_btn_s;
                m_run    = 0;
                m_pend   = (m_stable == 0);
            end
        end else begin
            m_run = 0;
        end
        if (press) begin
            if (!m_frozen) for (int k = 0; k < NUM_CH; k++) m_snap[k] = live(k);
            m_frozen = !m_frozen;
        end
        if (m_mode_s) begin
            if (m_presc == SDIV - 1) begin
                m_presc = 0;
                m_ch    = (m_ch + 1) % NUM_CH;
            end else begin
                m_presc++;
            end
        end else begin
            m_presc = 0;
            if (legal) m_ch = m_sel_s;
        end
        m_disp   = word;
        m_sel_s  = m_sel_p;  m_sel_p  = int'(sel_sw);
        m_mode_s = m_mode_p; m_mode_p = int'(mode_auto);
        m_btn_s  = m_btn_p;  m_btn_p  = int'(freeze_btn_n);
    endtask

    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) model_reset();
        else          model_step();
    end

    // ---------------- checking helpers -----------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " frozen"},  64'(frozen),  64'(m_frozen));
        check({tag, " cur_ch"},  64'(cur_ch),  64'(exp_cur()));
        check({tag, " sel_err"}, 64'(sel_err), 64'(exp_err()));
        check({tag, " hex_seg"}, 64'(hex_seg), 64'(exp_hex(m_disp)));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " frozen"},  64'(frozen),  64'(0));
        check({tag, " cur_ch"},  64'(cur_ch),  64'(0));
        check({tag, " sel_err"}, 64'(sel_err), 64'(0));
        check({tag, " hex_seg"}, 64'(hex_seg), 64'(exp_hex(0)));
    endtask

    task automatic tick(input int n, input string tag);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
            check_model(tag);
        end
    endtask

    // ---------------- directed + random stimulus -------------------------
    initial begin : stim
        int prev_ch, next_ch;
        logic [63:0] snap_val;

        Reset_n      = 1'b0;
        ch_data      = {16'hDEAD, 16'hBEEF, 16'h1234, 16'h00A5};
        sel_sw       = 3'd2;
        mode_auto    = 1'b0;
        freeze_btn_n = 1'b1;
        model_reset();
        #1;
        check_reset_vals("reset");
        repeat (3) @(negedge CLK);
        Reset_n = 1'b1;

        // 1: manual select reaches the display three cycles after release
        tick(2, "t1");
        check("t1 cur_ch", 64'(cur_ch), 64'(2));
        tick(1, "t1");
        check("t1 hex BEEF", 64'(hex_seg), 64'(exp_hex('hBEEF)));
        tick(4, "t1");

        // 2: short glitches rejected, clean press freezes the display
        repeat (2) begin
            freeze_btn_n = 1'b0; tick(2, "t2 glitch");
            freeze_btn_n = 1'b1; tick(3, "t2 glitch");
        end
        tick(3, "t2");
        check("t2 glitch frozen", 64'(frozen), 64'(0));
        freeze_btn_n = 1'b0; tick(8, "t2 press");
        check("t2 frozen", 64'(frozen), 64'(1));
        ch_data[47:32] = 16'h5555;
        tick(2, "t2");
        check("t2 hex held", 64'(hex_seg), 64'(exp_hex('hBEEF)));
        freeze_btn_n = 1'b1; tick(8, "t2 release");
        check("t2 still frozen", 64'(frozen), 64'(1));
        freeze_btn_n = 1'b0; tick(8, "t2 press2");
        check("t2 unfrozen", 64'(frozen), 64'(0));
        check("t2 hex 5555", 64'(hex_seg), 64'(exp_hex('h5555)));
        freeze_btn_n = 1'b1; tick(8, "t2 release2");

        // 3: auto-scan 2,3,0,1 with an 8-cycle dwell
        mode_auto = 1'b1;
        tick(2, "t3"); check("t3 ch2 start", 64'(cur_ch), 64'(2));
        tick(7, "t3"); check("t3 ch2 end",   64'(cur_ch), 64'(2));
        tick(1, "t3"); check("t3 ch3",       64'(cur_ch), 64'(3));
        tick(1, "t3"); check("t3 hex DEAD",  64'(hex_seg), 64'(exp_hex('hDEAD)));
        tick(7, "t3"); check("t3 ch0",       64'(cur_ch), 64'(0));
        tick(1, "t3"); check("t3 hex 00A5",  64'(hex_seg), 64'(exp_hex('h00A5)));
        tick(7, "t3"); check("t3 ch1",       64'(cur_ch), 64'(1));
        tick(1, "t3"); check("t3 hex 1234",  64'(hex_seg), 64'(exp_hex('h1234)));

        // 4: out-of-range manual select
        mode_auto = 1'b0;
        for (int s = 5; s < 8; s++) begin
            sel_sw = 3'(s);
            tick(3, "t4");
            check("t4 sel_err", 64'(sel_err), 64'(1));
            check("t4 hex zero", 64'(hex_seg), 64'(exp_hex(0)));
        end
        sel_sw = 3'd3;
        tick(3, "t4");
        check("t4 sel_err clear", 64'(sel_err), 64'(0));
        check("t4 hex DEAD", 64'(hex_seg), 64'(exp_hex('hDEAD)));

        // 5: press pulse lands on the same cycle as a scan tick
        mode_auto = 1'b1;
        tick(2, "t5");
        for (int i = 0; i < 3 * SDIV && m_presc != 1; i++) tick(1, "t5 align");
        prev_ch = m_ch;
        next_ch = (prev_ch + 1) % NUM_CH;
        freeze_btn_n = 1'b0;
        tick(6, "t5 press");
        snap_val = {$urandom, $urandom};
        ch_data  = snap_val;
        tick(1, "t5 coincide");
        check("t5 frozen", 64'(frozen), 64'(1));
        check("t5 cur_ch advanced", 64'(cur_ch), 64'(next_ch));
        ch_data = ~snap_val;
        tick(1, "t5 snap");
        check("t5 hex snapshot", 64'(hex_seg), 64'(exp_hex(int'(snap_val[next_ch*CH_W +: CH_W]))));
        tick(3, "t5 scan");

        // reset while frozen, mid-scan, with the button still held down
        #3 Reset_n = 1'b0;
        #1 check_reset_vals("t5 reset");
        @(negedge CLK);
        check_reset_vals("t5 in reset");
        Reset_n = 1'b1;
        tick(12, "t5 held");
        check("t5 held not accepted", 64'(frozen), 64'(0));
        freeze_btn_n = 1'b1; tick(8, "t5 release");
        freeze_btn_n = 1'b0; tick(8, "t5 repress");
        check("t5 repress frozen", 64'(frozen), 64'(1));
        freeze_btn_n = 1'b1; tick(8, "t5 release2");

        // random phase against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0)   ch_data      = {$urandom, $urandom};
            if ($urandom_range(0, 40) == 0)  mode_auto    = ~mode_auto;
            if ($urandom_range(0, 10) == 0)  sel_sw       = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0)   freeze_btn_n = ~freeze_btn_n;
            if ($urandom_range(0, 300) == 0) begin
                Reset_n = 1'b0;
                #1 check_model("rand reset");
                #1 Reset_n = 1'b1;
            end
            tick(1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/debug_view_ctrl.md
Name: debug_view_ctrl

Overview:
Parametrised debug-display controller for board top levels. It selects one of NUM_CH probe words by switch or by auto-scan, and can freeze a snapshot of all channels on a debounced button press. The selected word drives active-low 7-segment patterns, one digit per nibble. It replaces the fixed 8:1 display mux, the separate button sync and key filter, and the per-digit hex decoders between the processor's debug outputs and the HEX displays.

Parameters:
NUM_CH, 8, number of probe channels (2..16)
CH_W, 16, probe width in bits; multiple of 4; digits = CH_W/4
SCAN_DIV, 50_000_000, auto-scan dwell per channel, in CLK cycles
DEBOUNCE_CYC, 500_000, cycles the synchronised button must be stable before it is accepted

Ports:
CLK  in  1  system clock (CLOCK_50 domain)
Reset_n  in  1  asynchronous active-low reset
ch_data  in  NUM_CH*CH_W  probe words; channel k = ch_data[k*CH_W +: CH_W]; synchronous to CLK
sel_sw  in  SEL_W=$clog2(NUM_CH)  manual channel select from raw switches
mode_auto  in  1  raw switch; 1 = auto-scan, 0 = manual
freeze_btn_n  in  1  raw KEY, active-low, asynchronous, bouncy
hex_seg  out  7*(CH_W/4)  segments; digit d = hex_seg[7*d +: 7], bit order a..g from MSB, active-low; digit 0 = least-significant nibble
cur_ch  out  SEL_W  channel currently displayed
frozen  out  1  snapshot mode active
sel_err  out  1  manual select is >= NUM_CH

Behaviour:
- Reset (async assert, sync release through the normal flops): frozen=0, cur_ch=0, scan prescaler=0, snapshot bank=0, display reg=0, so hex_seg shows all "0" (7'b0000001 per digit). sel_err=0.
- Reset asserted mid-operation (mid-debounce, mid-scan, frozen) clears everything above. A button held through reset release is not accepted until it is released and pressed again.
- Input conditioning: sel_sw, mode_auto and freeze_btn_n each pass a 2-flop synchroniser.
- Button path: the synchronised button feeds a stability counter. The stable level changes only after DEBOUNCE_CYC consecutive equal samples. A 1-cycle press pulse fires on the stable 1->0 transition.
- Press pulse toggles frozen.
  - On 0->1, the snapshot bank captures all NUM_CH channels from ch_data in that same cycle.
  - While frozen, the display sources the snapshot bank. Otherwise it sources live ch_data.
- Channel index, manual (synced mode_auto=0): cur_ch = synced sel_sw.
  - If sel_sw >= NUM_CH: sel_err=1, display word = 0, and cur_ch holds its last legal value.
- Channel index, auto:
  - The prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and cur_ch increments, wrapping NUM_CH-1 -> 0.
  - sel_err=0 in auto mode.
- Manual->auto transition: cur_ch keeps its current value and the prescaler clears. Auto->manual: cur_ch follows sel_sw on the next cycle.
- Auto-scan continues while frozen, so the user can browse the snapshot.
- Press pulse and scan tick in the same cycle: both take effect. The snapshot captures the data present that cycle, and cur_ch advances.
- Display register: the selected word is registered, then decoded combinationally to hex_seg. Latency from ch_data/cur_ch change to hex_seg is 1 CLK. Latency from a raw switch change is 3 CLK (2 sync + 1).
- Decode: 0-9, A, b, C, d, E, F in standard DE2 encoding.

Decomposition:
- Package debug_view_pkg:
  - seg7_t typedef (logic [0:6])
  - SEG_BLANK and SEG_ZERO constants
  - function hex_to_seg(logic [3:0]) returning seg7_t
  - localparam helper for SEL_W
- Sub-module key_conditioner (params DEBOUNCE_CYC): CLK, Reset_n, raw_n in; stable_n and press_pulse out. It is reusable for KEY[3:0] in later tops.

Test Plan (NUM_CH=4, CH_W=16, SCAN_DIV=8, DEBOUNCE_CYC=4):
1. Reset, then release with ch_data = {16'hDEAD, 16'hBEEF, 16'h1234, 16'h00A5}, manual, sel_sw=2 -> hex_seg decodes BEEF 3 cycles after release. cur_ch=2.
2. Press freeze_btn_n with 2-cycle glitches (shorter than 4) -> frozen stays 0. A clean low held 6+ cycles -> frozen=1 after sync+debounce; change ch_data[2] to 16'h5555 -> display stays BEEF; next press -> shows 5555.
3. Auto mode from cur_ch=2 -> cur_ch advances 2,3,0,1 every 8 cycles. Each value is displayed 1 cycle after cur_ch changes.
4. Manual sel_sw=5 with NUM_CH=6 and ch_data width adjusted to match, then NUM_CH=4 with sel_sw=5 (SEL_W=3 build) -> sel_err=1 and display 0000.
5. Press pulse coincident with a scan tick -> snapshot equals that cycle's ch_data and cur_ch advances. Reset asserted while frozen, mid-scan -> all outputs back to reset values immediately.
